// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM read sequencer for a radix-2 DIT FFT: one address per butterfly, all stages.
// Latency: Start sampled in IDLE -> first address valid on the next edge; then up to one address per cycle.
// Backpressure: Addr_ready low holds the current beat stable; Abort drops it on the next edge.
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   Start, Abort      begin a sweep (IDLE only) / abandon the sweep in progress (RUN only)
//   Addr_ready        consumer accepts the current beat
//   Addr_valid        Address/Stage/Bfly_idx/Stage_last are valid
//   Address           twiddle exponent for (Stage, Bfly_idx), zero-extended
//   Stage, Bfly_idx   stage s and butterfly k of the current beat
//   Stage_last        current beat is the last butterfly of its stage
//   Busy, Done        sweep in progress / one-cycle pulse after the final transfer
module twiddle_addr_gen #(
  parameter int LOG2_NFFT  = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Addr_ready,
  output logic                  Addr_valid,
  output logic [DATA_WIDTH-1:0] Address,
  output logic [LOG2_NFFT-1:0]  Stage,
  output logic [LOG2_NFFT-2:0]  Bfly_idx,
  output logic                  Stage_last,
  output logic                  Busy,
  output logic                  Done
);

  localparam int SW = LOG2_NFFT;
  localparam int KW = LOG2_NFFT - 1;
  localparam logic [KW-1:0] K_LAST = '1;                 // N/2-1
  localparam logic [SW-1:0] S_LAST = SW'(LOG2_NFFT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [KW-1:0]           k_q, k_d;

  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [KW-1:0]           bfly_q, bfly_d;

  // Exponent for butterfly k of stage s: (k mod 2**s) scaled up so that
  // every stage indexes the same N/2-entry ROM.
  function automatic logic [KW-1:0] twiddle(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [SW-1:0] mask;
    logic [KW-1:0] j;
    logic [SW-1:0] sh;
    mask = (SW'(1) << s) - SW'(1);
    j    = k & mask[KW-1:0];
    sh   = S_LAST - s;
    return j << sh;
  endfunction

  // State and output registers. Outputs are computed from next-state values
  // so every port comes straight from a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  // Next-state and counter advance. In RUN, valid is always high, so
  // Addr_ready alone marks a transfer.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (Abort) begin
          state_d = ST_IDLE;
          s_d     = '0;
          k_d     = '0;
        end else if (Addr_ready) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
              s_d     = '0;
            end else begin
              s_d = s_q + SW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    last_d  = 1'b0;
    addr_d  = '0;
    stage_d = '0;
    bfly_d  = '0;
    if (state_d == ST_RUN) begin
      last_d  = (k_d == K_LAST);
      addr_d  = DATA_WIDTH'(twiddle(s_d, k_d));
      stage_d = s_d;
      bfly_d  = k_d;
    end
  end

  assign Addr_valid = valid_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Stage_last = last_q;
  assign Address    = addr_q;
  assign Stage      = stage_q;
  assign Bfly_idx   = bfly_q;

endmodule
